// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Definitions shared by the RV32 instruction fetch slice.
//   NOP_INSN          canonical RV32 NOP (addi x0,x0,0), shown on if_ir when
//                     nothing valid is presented
//   DEFAULT_RESET_PC  default first fetch address after reset
//   CNT_W             width of the occupancy / in-flight counters (holds 0..8)
//   fetch_state_t     fetch FSM encoding: BOOT, RUN, FLUSH
//   fetch_entry_t     one instruction buffer entry: {ir, pc}
//   word_align()      clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          CNT_W            = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// -----------------------------------------------------------------------------
// rv32_fetch_fifo
// Synchronous instruction buffer of DEPTH entries, each holding {ir, pc}.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_ir/pc  write one entry (ignored when full or flushing)
//   pop               drop the head entry (ignored when empty)
//   flush             empty the buffer; wins over push and pop
//   full, empty       status flags
//   count             number of valid entries
//   head_ir, head_pc  head entry; NOP / 0 while the buffer is empty
// -----------------------------------------------------------------------------
module rv32_fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [31:0]      push_ir,
    input  logic [31:0]      push_pc,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [31:0]      head_ir,
    output logic [31:0]      head_pc
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // An empty buffer presents a NOP at PC 0 so decode never sees stale data.
    assign head_ir = empty ? NOP_INSN : mem[rd_ptr].ir;
    assign head_pc = empty ? '0       : mem[rd_ptr].pc;

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_ir, push_pc};
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/rv32_fetch_unit.sv
// -----------------------------------------------------------------------------
// rv32_fetch_unit
// RV32 instruction fetch: issues word-aligned requests to instruction memory
// under a credit limit, buffers in-order responses with their PCs, presents
// them to decode, and handles branch/jump redirects by discarding stale data.
// Parameters: RESET_PC (first fetch address), BUF_DEPTH (2..8).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid, imem_rsp_data    in-order response (no back-pressure)
//   redirect_valid, redirect_pc      redirect from downstream
//   if_valid/ready, if_ir, if_pc     instruction presented to decode
//   perf_redirects                   redirect counter, present only when
//                                    RV32_FETCH_PERF_EN is defined
// -----------------------------------------------------------------------------
module rv32_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_ir,
    output logic [31:0] if_pc
`ifdef RV32_FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirects
`endif
);

    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(BUF_DEPTH);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] live_cnt;
    logic [CNT_W-1:0] stale_cnt;
    logic [CNT_W-1:0] buf_cnt;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] in_flight_next;
    logic [CNT_W-1:0] stale_next;
    logic [CNT_W:0]   occupancy;
    logic             accept;
    logic             rsp_ok;
    logic             rsp_live;
    logic             rsp_stale;
    logic             push;
    logic             pop;
    logic             buf_full;
    logic             buf_empty;
    logic [31:0]      rsp_pc;

    rv32_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_ir (imem_rsp_data),
        .push_pc (rsp_pc),
        .pop     (pop),
        .flush   (redirect_valid),
        .full    (buf_full),
        .empty   (buf_empty),
        .count   (buf_cnt),
        .head_ir (if_ir),
        .head_pc (if_pc)
    );

    assign if_valid  = !buf_empty;
    assign imem_addr = pc;

    // Credit check and response classification. Responses return in order,
    // so while any stale request is outstanding the next response must be
    // stale. Live requests since the last redirect were issued back to back,
    // so the oldest one's address is pc minus four per live request.
    always_comb begin
        in_flight      = live_cnt + stale_cnt;
        occupancy      = {1'b0, buf_cnt} + {1'b0, in_flight};
        imem_req_valid = (state == RUN) && (occupancy < DEPTH_W);
        accept         = imem_req_valid && imem_req_ready;
        rsp_ok         = imem_rsp_valid && (in_flight != '0);
        rsp_stale      = rsp_ok && (stale_cnt != '0);
        rsp_live       = rsp_ok && (stale_cnt == '0);
        push           = rsp_live && !redirect_valid && !buf_full;
        pop            = if_valid && if_ready;
        rsp_pc         = pc - 32'({live_cnt, 2'b00});
        in_flight_next = in_flight + CNT_W'(accept) - CNT_W'(rsp_ok);
        stale_next     = stale_cnt - CNT_W'(rsp_stale);
    end

    // Fetch FSM with the pc and request counters. A redirect turns every
    // outstanding request (including one accepted this cycle) stale, and
    // FLUSH holds off new requests until all of them have returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            live_cnt  <= '0;
            stale_cnt <= '0;
        end else if (redirect_valid) begin
            pc        <= word_align(redirect_pc);
            live_cnt  <= '0;
            stale_cnt <= in_flight_next;
            state     <= (in_flight_next != '0) ? FLUSH : RUN;
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
            end
            live_cnt  <= live_cnt + CNT_W'(accept) - CNT_W'(rsp_live);
            stale_cnt <= stale_next;
            case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                FLUSH:   state <= (stale_next == '0) ? RUN : FLUSH;
                default: state <= BOOT;
            endcase
        end
    end

`ifdef RV32_FETCH_PERF_EN
    // Saturating count of redirect cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redirects <= '0;
        end else if (redirect_valid && (perf_redirects != 32'hFFFF_FFFF)) begin
            perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_rv32_fetch_unit
// Self-checking bench for rv32_fetch_unit. A behavioural memory answers
// requests in order, and a queue-based reference model tracks the fetch pc,
// outstanding requests (live or stale) and the instruction buffer contents.
// Directed sequences cover boot, stall, flush, wrap and same-cycle redirect;
// a randomized phase follows. Build with RV32_FETCH_PERF_EN to include the
// perf_redirects checks.
// -----------------------------------------------------------------------------
module tb_rv32_fetch_unit;
    import rv32_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
`ifdef RV32_FETCH_PERF_EN
    logic [31:0] perf_redirects;
`endif

    rv32_fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_ir          (if_ir),
        .if_pc          (if_pc)
`ifdef RV32_FETCH_PERF_EN
        ,
        .perf_redirects (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          age;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] fetch_pc;
    bit          boot;
    logic [31:0] perf_model;
    int          check_count = 0;
    int          pass_count  = 0;

    bit          obs_req_valid;
    bit          obs_accept;
    logic [31:0] obs_addr;
    bit          obs_if_valid;
    bit          obs_hs;
    logic [31:0] obs_if_pc;
    logic [31:0] obs_if_ir;

    // Contents of instruction memory at any address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs; the memory only answers requests that were
    // accepted in an earlier cycle, oldest first.
    task automatic applyStimulus(input bit ready, input bit rsp_go, input bit redir,
                                 input logic [31:0] tgt, input bit ifr);
        imem_req_ready = ready;
        if (rsp_go && (mem_q.size() > 0) && (mem_q[0].age >= 1)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : $urandom;
        if_ready       = ifr;
    endtask

    // Mid-cycle: compare outputs against the model, then advance the model
    // with this cycle's events and move to just after the next rising edge.
    task automatic stepCycle();
        bit          exp_req;
        bit          stale_any;
        bit          accept;
        bit          hs;
        bit          do_push;
        logic [31:0] push_addr;
        req_t        r;
        @(negedge clk);
        assert (!(imem_rsp_valid && (mem_q.size() == 0)))
            else $error("[TB] protocol error: response with nothing in flight");
        stale_any = 1'b0;
        foreach (mem_q[i]) if (mem_q[i].stale) stale_any = 1'b1;
        exp_req = !boot && !stale_any && ((buf_q.size() + mem_q.size()) < DEPTH);
        checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) checkOutput("req_addr", imem_addr, fetch_pc);
        checkOutput("if_valid", 32'(if_valid), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) begin
            checkOutput("if_pc", if_pc, buf_q[0]);
            checkOutput("if_ir", if_ir, mem_word(buf_q[0]));
        end
`ifdef RV32_FETCH_PERF_EN
        checkOutput("perf_redirects", perf_redirects, perf_model);
`endif
        obs_req_valid = imem_req_valid;
        obs_accept    = imem_req_valid && imem_req_ready;
        obs_addr      = imem_addr;
        obs_if_valid  = if_valid;
        obs_hs        = if_valid && if_ready;
        obs_if_pc     = if_pc;
        obs_if_ir     = if_ir;

        accept    = exp_req && imem_req_ready;
        hs        = (buf_q.size() != 0) && if_ready;
        do_push   = 1'b0;
        push_addr = '0;
        if (imem_rsp_valid && (mem_q.size() > 0)) begin
            r = mem_q.pop_front();
            if (!r.stale && !redirect_valid) begin
                do_push   = 1'b1;
                push_addr = r.addr;
            end
        end
        if (hs) void'(buf_q.pop_front());
        if (do_push) buf_q.push_back(push_addr);
        if (accept) begin
            r.addr  = fetch_pc;
            r.stale = 1'b0;
            r.age   = 0;
            mem_q.push_back(r);
        end
        if (redirect_valid) begin
            buf_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            fetch_pc = redirect_pc & 32'hFFFF_FFFC;
            if (perf_model != 32'hFFFF_FFFF) perf_model = perf_model + 32'd1;
        end else if (accept) begin
            fetch_pc = fetch_pc + 32'd4;
        end
        foreach (mem_q[i]) mem_q[i].age = mem_q[i].age + 1;
        boot = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset, checks the asynchronous reset values, abandons all
    // outstanding traffic and releases reset just after a rising edge.
    task automatic resetDut();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_addr", imem_addr, RST_PC);
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_if_ir", if_ir, 32'h0000_0013);
        checkOutput("rst_if_pc", if_pc, 32'd0);
`ifdef RV32_FETCH_PERF_EN
        checkOutput("rst_perf", perf_redirects, 32'd0);
`endif
        mem_q.delete();
        buf_q.delete();
        fetch_pc   = RST_PC;
        boot       = 1'b1;
        perf_model = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
            stepCycle();
        end
    endtask

    initial begin
        logic [31:0] acc_list[$];
        int          first_acc;
        int          first_vld;
        logic [31:0] first_pc;
        logic [31:0] first_ir;
        logic [31:0] first_addr;
        logic [31:0] held_ir;
        int          ir_changes;
        bit          got_acc;
        bit          got_vld;

        resetDut();

        // Boot: continuous fetch with a one-cycle memory.
        first_acc = -1;
        first_vld = -1;
        first_pc  = 32'hDEAD_BEEF;
        first_ir  = 32'hDEAD_BEEF;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
            stepCycle();
            if (obs_accept) acc_list.push_back(obs_addr);
            if (obs_accept && (first_acc < 0)) first_acc = c;
            if (obs_if_valid && (first_vld < 0)) begin
                first_vld = c;
                first_pc  = obs_if_pc;
                first_ir  = obs_if_ir;
            end
        end
        checkOutput("boot_issue_cnt", 32'(acc_list.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i < acc_list.size()) checkOutput("boot_addr", acc_list[i], 32'(4 * i));
        end
        checkOutput("boot_latency", 32'(first_vld - first_acc), 32'd2);
        checkOutput("boot_if_pc", first_pc, 32'd0);
        checkOutput("boot_if_ir", first_ir, mem_word(32'd0));

        // Decode stalled: credits run out and the head stays put.
        ir_changes = 0;
        held_ir    = if_ir;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
            stepCycle();
            if (c == 2) held_ir = obs_if_ir;
            if ((c > 2) && (obs_if_ir !== held_ir)) ir_changes++;
        end
        checkOutput("stall_req_valid", 32'(obs_req_valid), 32'd0);
        checkOutput("stall_ir_changes", 32'(ir_changes), 32'd0);
        drain();

        // Redirect to an unaligned target with two requests in flight.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        checkOutput("flush_req_blocked", 32'(obs_req_valid), 32'd0);
        checkOutput("flush_if_valid", 32'(obs_if_valid), 32'd0);
        got_acc    = 1'b0;
        got_vld    = 1'b0;
        first_addr = 32'hDEAD_BEEF;
        first_pc   = 32'hDEAD_BEEF;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
            stepCycle();
            if (!got_acc && obs_accept) begin
                got_acc    = 1'b1;
                first_addr = obs_addr;
            end
            if (!got_vld && obs_if_valid) begin
                got_vld  = 1'b1;
                first_pc = obs_if_pc;
            end
        end
        checkOutput("redir_first_addr", first_addr, 32'h0000_0100);
        checkOutput("redir_first_pc", first_pc, 32'h0000_0100);
        drain();

        // Address wrap at the top of memory.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        stepCycle();
        acc_list.delete();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
            stepCycle();
            if (c == 0) begin
                checkOutput("norm_redir_req", 32'(obs_req_valid), 32'd1);
                checkOutput("norm_redir_addr", obs_addr, 32'hFFFF_FFFC);
            end
            if (obs_accept) acc_list.push_back(obs_addr);
        end
        checkOutput("wrap_issue_cnt", 32'(acc_list.size() >= 2), 32'd1);
        if (acc_list.size() >= 2) checkOutput("wrap_addr", acc_list[1], 32'd0);
        drain();

        // Redirect, live response and decode handshake in the same cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        stepCycle();
        checkOutput("same_cycle_hs", 32'(obs_hs), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        checkOutput("same_cycle_if_valid", 32'(obs_if_valid), 32'd0);
        checkOutput("same_cycle_req", 32'(obs_req_valid), 32'd1);
        checkOutput("same_cycle_addr", obs_addr, 32'h0000_0200);

        // Randomized traffic with an asynchronous reset in the middle.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) resetDut();
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0,
                          ($urandom % 20) == 0, $urandom, ($urandom % 3) != 0);
            stepCycle();
        end

`ifdef RV32_FETCH_PERF_EN
        // Three redirects, then reset clears the counter.
        resetDut();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 32'(c * 64), 1'b1);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        stepCycle();
        checkOutput("perf_three", perf_redirects, 32'd3);
        resetDut();
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
